sync_fifo_thr: RTL and testbench

SYNC_FIFO_THR -- requirements
Module: sync_fifo_thr

---
 rtl/sync_fifo_thr.sv | 127 ++++++++++++
 tb/tb_sync_fifo_thr.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_thr.sv
// Single-clock FIFO with registered occupancy/threshold flags, sticky overflow/underflow
// errors and a selectable registered or first-word-fall-through read port.
module sync_fifo_thr #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned AF_LVL = DEPTH - 2,
  parameter int unsigned AE_LVL = 2,
  parameter bit          FWFT   = 1'b0
) (
  input  logic                     clk_in,
  input  logic                     rst,
  input  logic                     wr_rq,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     rd_rq,
  input  logic                     clr_err,
  output logic [WIDTH-1:0]         rdata,
  output logic                     rd_valid,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DepthC = CW'(DEPTH);
  localparam logic [CW-1:0] AfLvlC = CW'(AF_LVL);
  localparam logic [CW-1:0] AeLvlC = CW'(AE_LVL);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             af_q, af_d;
  logic             ae_q, ae_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             wr_acc, rd_acc;

  // Acceptance uses registered flags, so a full FIFO only drains and an empty one only fills.
  assign wr_acc = wr_rq & ~full_q & ~rst;
  assign rd_acc = rd_rq & ~empty_q & ~rst;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (wr_acc) wptr_d = wptr_q + AW'(1);
    if (rd_acc) rptr_d = rptr_q + AW'(1);
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    full_d  = (count_d == DepthC);
    empty_d = (count_d == '0);
    af_d    = (count_d >= AfLvlC);
    ae_d    = (count_d <= AeLvlC);
    // A new error condition wins over a simultaneous clear.
    ovf_d   = (ovf_q & ~clr_err) | (wr_rq & full_q);
    unf_d   = (unf_q & ~clr_err) | (rd_rq & empty_q);
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      af_q    <= 1'b0;
      ae_q    <= 1'b1;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      af_q    <= af_d;
      ae_q    <= ae_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (wr_acc) mem_q[wptr_q] <= wdata;
  end

  if (FWFT) begin : g_fwft
    // Gating with empty keeps stale memory from ever reaching the port.
    assign rdata    = empty_q ? '0 : mem_q[rptr_q];
    assign rd_valid = ~empty_q;
  end else begin : g_reg
    logic [WIDTH-1:0] rdata_q;
    logic             rd_valid_q;

    always_ff @(posedge clk_in) begin
      if (rst) begin
        rdata_q    <= '0;
        rd_valid_q <= 1'b0;
      end else begin
        rd_valid_q <= rd_acc;
        if (rd_acc) rdata_q <= mem_q[rptr_q];
      end
    end

    assign rdata    = rdata_q;
    assign rd_valid = rd_valid_q;
  end

  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule

// File: tb/tb_sync_fifo_thr.sv
// Drives a registered-read and a FWFT instance with shared stimulus and compares both
// against a queue-based reference model every cycle.
module tb_sync_fifo_thr;

  localparam int W  = 4;
  localparam int D  = 8;
  localparam int AF = 6;
  localparam int AE = 2;

  logic         clk = 1'b0;
  logic         rst, wr_rq, rd_rq, clr_err;
  logic [W-1:0] wdata;

  logic [W-1:0] rdata0, rdata1;
  logic         rv0, rv1, full0, full1, empty0, empty1, af0, af1, ae0, ae1;
  logic         ovf0, ovf1, unf0, unf1;
  logic [3:0]   count0, count1;

  always #5 clk = ~clk;

  sync_fifo_thr #(.WIDTH(W), .DEPTH(D), .AF_LVL(AF), .AE_LVL(AE), .FWFT(1'b0)) u_reg (
    .clk_in(clk), .rst(rst), .wr_rq(wr_rq), .wdata(wdata), .rd_rq(rd_rq), .clr_err(clr_err),
    .rdata(rdata0), .rd_valid(rv0), .full(full0), .empty(empty0), .almost_full(af0),
    .almost_empty(ae0), .count(count0), .overflow(ovf0), .underflow(unf0)
  );

  sync_fifo_thr #(.WIDTH(W), .DEPTH(D), .AF_LVL(AF), .AE_LVL(AE), .FWFT(1'b1)) u_fwft (
    .clk_in(clk), .rst(rst), .wr_rq(wr_rq), .wdata(wdata), .rd_rq(rd_rq), .clr_err(clr_err),
    .rdata(rdata1), .rd_valid(rv1), .full(full1), .empty(empty1), .almost_full(af1),
    .almost_empty(ae1), .count(count1), .overflow(ovf1), .underflow(unf1)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: contents as a plain queue plus the observable registered state.
  logic [W-1:0] q[$];
  bit           m_ovf, m_unf, m_rv;
  logic [W-1:0] m_rdata;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic compare_all();
    int sz;
    sz = q.size();
    check_eq("count0", count0, sz);
    check_eq("count1", count1, sz);
    check_eq("full0", full0, sz == D);
    check_eq("full1", full1, sz == D);
    check_eq("empty0", empty0, sz == 0);
    check_eq("empty1", empty1, sz == 0);
    check_eq("afull0", af0, sz >= AF);
    check_eq("afull1", af1, sz >= AF);
    check_eq("aempty0", ae0, sz <= AE);
    check_eq("aempty1", ae1, sz <= AE);
    check_eq("ovf0", ovf0, m_ovf);
    check_eq("ovf1", ovf1, m_ovf);
    check_eq("unf0", unf0, m_unf);
    check_eq("unf1", unf1, m_unf);
    check_eq("rvalid0", rv0, m_rv);
    check_eq("rdata0", rdata0, m_rdata);
    check_eq("rvalid1", rv1, sz != 0);
    check_eq("rdata1", rdata1, (sz != 0) ? q[0] : '0);
  endtask

  task automatic step(input bit r, input bit w, input logic [W-1:0] wd, input bit rd,
                      input bit clr);
    bit wa, ra;
    int sz;
    rst = r; wr_rq = w; wdata = wd; rd_rq = rd; clr_err = clr;
    @(posedge clk);
    sz = q.size();
    if (r) begin
      q.delete();
      m_ovf = 0; m_unf = 0; m_rv = 0; m_rdata = '0;
    end else begin
      wa    = w && (sz < D);
      ra    = rd && (sz > 0);
      m_ovf = (m_ovf && !clr) || (w && sz == D);
      m_unf = (m_unf && !clr) || (rd && sz == 0);
      m_rv  = ra;
      if (ra) m_rdata = q.pop_front();
      if (wa) q.push_back(wd);
    end
    #1;
    compare_all();
  endtask

  initial begin
    int pw;
    bit w, rd, r, c;
    rst = 1; wr_rq = 0; rd_rq = 0; clr_err = 0; wdata = '0;
    @(negedge clk);
    step(1, 0, 0, 0, 0);
    step(1, 1, 4'h5, 1, 0);  // requests during reset are ignored
    check_eq("rst_empty", empty0, 1'b1);

    // Fill to full, then overflow
    for (int i = 1; i <= 8; i++) step(0, 1, W'(i), 0, 0);
    check_eq("r33_count", count0, 8);
    step(0, 1, 4'h9, 0, 0);
    check_eq("r33_ovf", ovf0, 1'b1);

    // Drain in order, then underflow
    for (int i = 1; i <= 8; i++) begin
      step(0, 0, 0, 1, 0);
      check_eq("r34_order", rdata0, i);
    end
    step(0, 0, 0, 1, 0);
    check_eq("r34_unf", unf0, 1'b1);
    step(0, 0, 0, 1, 1);     // clear loses to a simultaneous set
    check_eq("clr_vs_set", unf0, 1'b1);
    step(0, 0, 0, 0, 1);
    check_eq("clr_done", ovf0 | unf0, 1'b0);

    // Simultaneous read/write on empty and on full
    step(0, 1, 4'h7, 1, 0);
    check_eq("r36_empty_both", count0, 1);
    for (int i = 0; i < 7; i++) step(0, 1, W'(i + 2), 0, 0);
    step(0, 1, 4'hF, 1, 0);
    check_eq("r36_full_both", count0, 7);

    // Hold both at count=4 across pointer wraps
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, W'(i), 0, 0);
    for (int i = 4; i < 24; i++) step(0, 1, W'(i), 1, 0);
    check_eq("r35_count", count0, 4);

    // Mid-operation reset
    step(0, 1, 4'hC, 0, 0);
    check_eq("r38_pre", count0, 5);
    step(1, 0, 0, 0, 0);
    step(0, 1, 4'h3, 0, 0);
    step(0, 0, 0, 1, 0);
    check_eq("r38_data", rdata0, 4'h3);

    // FWFT visibility
    step(0, 1, 4'hA, 0, 0);
    check_eq("r37_rdata", rdata1, 4'hA);
    check_eq("r37_valid", rv1, 1'b1);
    step(0, 0, 0, 1, 0);
    check_eq("r37_after", rv1, 1'b0);

    // Randomised traffic with phase-varying write/read bias
    pw = 50;
    for (int n = 0; n < 3000; n++) begin
      if (n % 64 == 0) pw = $urandom_range(10, 90);
      w  = ($urandom_range(0, 99) < pw);
      rd = ($urandom_range(0, 99) < (100 - pw));
      r  = ($urandom_range(0, 199) == 0);
      c  = ($urandom_range(0, 15) == 0);
      step(r, w, W'($urandom), rd, c);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
